w_pattern_gen: RTL and testbench

- Serial stimulus transmitter that drives the single-bit `w` line consumed by the lab sequence-detector FSM and output decoder.
- Serializes a programmable bit pattern MSB-first.
- Holds each bit for a programmable number of clock cycles so the detector's counter-based timing can be exercised.
- Start/busy/done handshake, repeat mode and synchronous abort. Sits between the board switches/test controller and the detector's `w` input.

---
 rtl/w_pattern_gen.sv | 202 ++++++++++++++++++++
 tb/tb_w_pattern_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/w_pattern_gen.sv
// w_pattern_gen: serial stimulus transmitter for the sequence-detector `w` line.
// Shifts a captured pattern out MSB-first, holding each bit for a programmable
// number of cycles, with start/busy/done handshake, repeat mode and abort.
// Optional build macro W_PATTERN_LFSR_EN adds an `lfsr_mode` input that sources
// the bits from a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) instead.
module w_pattern_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 5,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [HOLD_WIDTH-1:0] hold,
  input  logic                  repeat_en,
`ifdef W_PATTERN_LFSR_EN
  input  logic                  lfsr_mode,
`endif
  output logic                  w,
  output logic                  w_valid,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  bit_idx
);

  localparam logic [LEN_WIDTH-1:0]  LEN_MAX = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] BIT0    = DATA_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;     // effective length L
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;   // effective hold minus one (H-1)
  logic                  rep_q, rep_d;
  logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;     // counts H-1 down to 0 per bit
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic                  w_q, w_d;
  logic                  wv_q, wv_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [LEN_WIDTH-1:0]  len_eff;
  logic [HOLD_WIDTH-1:0] hold_m1;

`ifdef W_PATTERN_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        mode_q, mode_d;
  logic [15:0] lfsr_seed;
  logic [15:0] lfsr_next;
`endif

  // Decode the zero/oversize conventions of the length and hold inputs.
  always_comb begin
    len_eff = length;
    if (length == '0 || length > LEN_MAX) len_eff = LEN_MAX;
    hold_m1 = (hold == '0) ? '0 : hold - 1'b1;
  end

`ifdef W_PATTERN_LFSR_EN
  // Seed selection (all-zero seed would lock up) and one-step LFSR advance.
  always_comb begin
    lfsr_seed = (pattern[15:0] == 16'h0000) ? 16'hACE1 : pattern[15:0];
    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  // Next-state and registered-output logic for the IDLE/SEND/DONE sequencer.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    w_d     = w_q;
    wv_d    = wv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef W_PATTERN_LFSR_EN
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        w_d    = 1'b0;
        wv_d   = 1'b0;
        busy_d = 1'b0;
        idx_d  = '0;
        // abort takes priority over a simultaneous start
        if (start && !abort) begin
          state_d = S_SEND;
          pat_d   = pattern;
          len_d   = len_eff;
          hold_d  = hold_m1;
          rep_d   = repeat_en;
          cnt_d   = hold_m1;
          idx_d   = len_eff - 1'b1;
          wv_d    = 1'b1;
          busy_d  = 1'b1;
          w_d     = |(pattern & (BIT0 << idx_d));
`ifdef W_PATTERN_LFSR_EN
          mode_d  = lfsr_mode;
          lfsr_d  = lfsr_seed;
          if (lfsr_mode) w_d = lfsr_seed[15];
`endif
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
          w_d     = 1'b0;
          wv_d    = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q != '0 || rep_q) begin
          // hold expired: next bit, wrapping to the MSB without a gap in repeat
          cnt_d = hold_q;
          idx_d = (idx_q != '0) ? idx_q - 1'b1 : len_q - 1'b1;
          w_d   = |(pat_q & (BIT0 << idx_d));
`ifdef W_PATTERN_LFSR_EN
          lfsr_d = lfsr_next;
          if (mode_q) w_d = lfsr_next[15];
`endif
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          w_d     = 1'b0;
          wv_d    = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
        end
      end
      S_DONE: begin
        // single-cycle completion pulse; start and abort are both ignored here
        state_d = S_IDLE;
        w_d     = 1'b0;
        wv_d    = 1'b0;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        w_d     = 1'b0;
        wv_d    = 1'b0;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      rep_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      w_q     <= 1'b0;
      wv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef W_PATTERN_LFSR_EN
      lfsr_q  <= '0;
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      wv_q    <= wv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef W_PATTERN_LFSR_EN
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
`endif
    end
  end

  assign w       = w_q;
  assign w_valid = wv_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_w_pattern_gen.sv
// Testbench for w_pattern_gen: directed test-plan cases plus randomized
// transfers, each checked cycle by cycle against an arithmetic reference model.
module tb_w_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic [7:0]  hold;
  logic        repeat_en;
`ifdef W_PATTERN_LFSR_EN
  logic        lfsr_mode;
`endif
  logic        w;
  logic        w_valid;
  logic        busy;
  logic        done;
  logic [4:0]  bit_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  w_pattern_gen #(.DATA_WIDTH(16), .LEN_WIDTH(5), .HOLD_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .length    (length),
    .hold      (hold),
    .repeat_en (repeat_en),
`ifdef W_PATTERN_LFSR_EN
    .lfsr_mode (lfsr_mode),
`endif
    .w         (w),
    .w_valid   (w_valid),
    .busy      (busy),
    .done      (done),
    .bit_idx   (bit_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ew, input logic ev,
                          input logic eb, input logic ed, input logic [4:0] ei);
    chk({tag, ".w"},       32'(w),       32'(ew));
    chk({tag, ".w_valid"}, 32'(w_valid), 32'(ev));
    chk({tag, ".busy"},    32'(busy),    32'(eb));
    chk({tag, ".done"},    32'(done),    32'(ed));
    chk({tag, ".bit_idx"}, 32'(bit_idx), 32'(ei));
  endtask

  function automatic int eff_len(input logic [4:0] l);
    if (l == 5'd0 || l > 5'd16) return 16;
    return int'(l);
  endfunction

  function automatic int eff_hold(input logic [7:0] h);
    return (h == 8'd0) ? 1 : int'(h);
  endfunction

  // One transfer: start at edge T, then every following cycle is compared with
  // the model. Repeat transfers run rep_len cycles and are then aborted.
  // noise=1 scrambles all inputs (including start) after capture and pulses
  // start during the DONE cycle; none of that may disturb the output.
  task automatic run(input string tag, input logic [15:0] p, input logic [4:0] l,
                     input logic [7:0] h, input logic rep, input int rep_len,
                     input logic noise, input logic use_lfsr);
    int L, H, total, j, idx;
    logic ebit;
    logic [15:0] s;
    L = eff_len(l);
    H = eff_hold(h);
    total = rep ? rep_len : L * H;
    s = (p == 16'h0000) ? 16'hACE1 : p;
    $display("txn %s pat=%h len=%0d hold=%0d rep=%0d lfsr=%0d cycles=%0d",
             tag, p, l, h, rep, use_lfsr, total);
    pattern = p; length = l; hold = h; repeat_en = rep; abort = 1'b0;
`ifdef W_PATTERN_LFSR_EN
    lfsr_mode = use_lfsr;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < total; k++) begin
      j = k / H;
      idx = L - 1 - (j % L);
      if (k > 0 && (k % H) == 0)
        s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      ebit = use_lfsr ? s[15] : p[idx];
      chk_outs({tag, ".send"}, ebit, 1'b1, 1'b1, 1'b0, 5'(idx));
      if (noise) begin
        start = 1'($urandom);
        pattern = 16'($urandom);
        length = 5'($urandom);
        hold = 8'($urandom);
        repeat_en = 1'($urandom);
`ifdef W_PATTERN_LFSR_EN
        lfsr_mode = 1'($urandom);
`endif
      end
      if (rep && k == total - 1) abort = 1'b1;
      step();
    end
    start = 1'b0;
    if (rep) begin
      abort = 1'b0;
      chk_outs({tag, ".abort"}, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    end else begin
      chk_outs({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
      if (noise) start = 1'b1;
      step();
      start = 1'b0;
      chk_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    end
    step();
    chk_outs({tag, ".idle2"}, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; length = '0;
    hold = '0; repeat_en = 1'b0;
`ifdef W_PATTERN_LFSR_EN
    lfsr_mode = 1'b0;
`endif
    step();
    step();
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;
    step();
    chk_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    run("basic",     16'h000B, 5'd4,  8'd1, 1'b0, 0, 1'b0, 1'b0);
    run("hold3",     16'h0002, 5'd2,  8'd3, 1'b0, 0, 1'b1, 1'b0);
    run("zero",      16'hA5A5, 5'd0,  8'd0, 1'b0, 0, 1'b0, 1'b0);
    run("rep_abort", 16'h0005, 5'd3,  8'd1, 1'b1, 5, 1'b0, 1'b0);
    run("len_sat",   16'h1234, 5'd20, 8'd2, 1'b0, 0, 1'b1, 1'b0);
    run("rep_noise", 16'h00C6, 5'd7,  8'd2, 1'b1, 40, 1'b1, 1'b0);

    // start and abort together in IDLE: abort wins
    $display("txn start_abort_idle");
    pattern = 16'hFFFF; length = 5'd4; hold = 8'd1; start = 1'b1; abort = 1'b1;
    step();
    chk_outs("start_abort", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    start = 1'b0; abort = 1'b0;
    step();
    chk_outs("start_abort2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    // reset in the middle of a transfer: immediate idle, no done pulse
    $display("txn reset_mid_transfer");
    pattern = 16'hFFFF; length = 5'd8; hold = 8'd2; repeat_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk_outs("rst_mid.pre", 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
    step();
    step();
    rst = 1'b1;
    step();
    chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;
    step();
    chk_outs("rst_mid.after", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    for (int i = 0; i < 20; i++) begin
      run("rand", 16'($urandom), 5'($urandom_range(0, 20)), 8'($urandom_range(0, 5)),
          1'($urandom_range(0, 1)), $urandom_range(1, 60), 1'b1, 1'b0);
    end

`ifdef W_PATTERN_LFSR_EN
    run("lfsr_seed0", 16'h0000, 5'd3, 8'd1, 1'b0, 0, 1'b0, 1'b1);
    run("lfsr_rep",   16'h1D0F, 5'd5, 8'd2, 1'b1, 37, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run("lfsr_rand", 16'($urandom), 5'($urandom_range(0, 20)), 8'($urandom_range(0, 4)),
          1'($urandom_range(0, 1)), $urandom_range(1, 50), 1'b1, 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
